// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: 8N1 frame constants, bit-period computation,
// receiver FSM state encoding and a 2-of-3 vote helper.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per bit; the transmitter uses the same rounding.
    function automatic int calc_ticks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the line into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, one-byte holding
// register with overrun detection, stop-bit framing error pulse.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int TICKS_PER_BIT = calc_ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int MID           = TICKS_PER_BIT / 2;

    localparam logic [15:0] TICK_LAST   = 16'(TICKS_PER_BIT - 1);
    localparam logic [15:0] TICK_MID_M1 = 16'(MID - 1);
    localparam logic [15:0] TICK_MID    = 16'(MID);
    localparam logic [15:0] TICK_MID_P1 = 16'(MID + 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic                   w_rxs;
    logic [15:0]            r_tick;
    logic [2:0]             r_bit_idx;
    logic                   r_armed;
    logic [1:0]             r_settle;
    logic                   r_samp_a;
    logic                   r_samp_b;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   w_tick_wrap;
    logic                   w_decide;
    logic                   w_bit_val;
    logic                   w_stop_decide;
    logic                   w_deliver;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (rx),
        .o_sync  (w_rxs)
    );

    assign w_tick_wrap   = (r_tick == TICK_LAST);
    assign w_decide      = (r_tick == TICK_MID_P1);
    assign w_bit_val     = majority3(r_samp_a, r_samp_b, w_rxs);
    assign w_stop_decide = (r_state == ST_STOP) && w_decide;
    assign w_deliver     = w_stop_decide && w_bit_val;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs && r_armed) w_next_state = ST_START;
                else                   w_next_state = ST_IDLE;
            end
            ST_START: begin
                if (w_decide && w_bit_val) w_next_state = ST_IDLE;
                else if (w_tick_wrap)      w_next_state = ST_DATA;
                else                       w_next_state = ST_START;
            end
            ST_DATA: begin
                if (w_tick_wrap && (r_bit_idx == LAST_BIT)) w_next_state = ST_STOP;
                else                                        w_next_state = ST_DATA;
            end
            ST_STOP: begin
                if (w_decide) w_next_state = ST_IDLE;
                else          w_next_state = ST_STOP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        rx_busy = 1'b0;
        if (r_state != ST_IDLE) rx_busy = 1'b1;
        else                    rx_busy = 1'b0;
    end

    // Bit timing, sampling, shifting and the output holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick     <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_armed    <= 1'b0;
            r_settle   <= 2'b00;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // The synchronizer's reset value is not a real line observation,
            // so arming waits until genuine samples have propagated through.
            r_settle <= {r_settle[0], 1'b1};

            if (r_state == ST_IDLE || w_tick_wrap) r_tick <= 16'd0;
            else                                   r_tick <= r_tick + 16'd1;

            if (r_state != ST_IDLE && r_tick == TICK_MID_M1) r_samp_a <= w_rxs;
            if (r_state != ST_IDLE && r_tick == TICK_MID)    r_samp_b <= w_rxs;

            if (r_state == ST_IDLE && w_rxs && r_settle[1]) r_armed <= 1'b1;
            else if (w_stop_decide)                         r_armed <= 1'b0;

            if (r_state == ST_START)                     r_bit_idx <= 3'd0;
            else if (r_state == ST_DATA && w_tick_wrap)  r_bit_idx <= r_bit_idx + 3'd1;

            if (r_state == ST_DATA && w_decide) r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};

            frame_err <= w_stop_decide && !w_bit_val;
            overrun   <= w_deliver && data_valid && !data_ready;

            if (w_deliver && (!data_valid || data_ready)) begin
                data_out   <= r_shift;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
